// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEFAULT       = 32;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    // Encoding doubles as priority: the highest active event wins.
    typedef enum logic [2:0] {
        EV_RUN       = 3'd0,
        EV_LOAD_USE  = 3'd1,
        EV_DRAIN     = 3'd2,
        EV_BRANCH    = 3'd3,
        EV_FREEZE    = 3'd4
    } ctrl_event_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc/clr one edge later.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freeze, branch, serialise, load-use.
// Latency: controls are combinational, same cycle as the inputs; state moves on the next edge.
// Backpressure: a pending data-memory access freezes every stage up to EX/MEM.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_serialize,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             pc_sel_target,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    ctrl_state_t state, state_nxt, saved_state, eff_state;
    ctrl_event_t ev;

    logic              ex_v, mem_v, wb_v;
    logic              freeze, pipe_empty, drain_act, load_use;
    logic              timeout_q;
    logic [WAIT_W-1:0] wait_cnt;

    assign freeze     = mem_req && !mem_ready;
    assign pipe_empty = !(ex_v || mem_v || wb_v);

    // While waiting on memory, decode as the state we were in before the wait.
    assign eff_state  = (state == MEM_WAIT) ? saved_state : state;

    assign drain_act  = !pipe_empty &&
                        ((eff_state == DRAIN) ||
                         ((eff_state == RUN) && id_valid && id_serialize));

    assign load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        ev = EV_RUN;
        if (freeze)               ev = EV_FREEZE;
        else if (ex_branch_taken) ev = EV_BRANCH;
        else if (drain_act)       ev = EV_DRAIN;
        else if (load_use)        ev = EV_LOAD_USE;
    end

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_write    = 1'b1;
        exmem_write   = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_bubble  = 1'b0;
        pc_sel_target = 1'b0;
        state_nxt     = RUN;

        case (ev)
            EV_FREEZE: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
                state_nxt    = MEM_WAIT;
            end
            EV_BRANCH: begin
                pc_sel_target = 1'b1;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
            end
            EV_DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                state_nxt  = DRAIN;
            end
            EV_LOAD_USE: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase

        if (!rst_n) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b0;
            exmem_write   = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            memwb_bubble  = 1'b1;
            pc_sel_target = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            saved_state <= RUN;
            ex_v        <= 1'b0;
            mem_v       <= 1'b0;
            wb_v        <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timeout_q <= mem_timeout;
            if (freeze && (state != MEM_WAIT)) begin
                saved_state <= state;
            end
            if (freeze) begin
                wb_v <= 1'b0;
            end else begin
                ex_v  <= id_valid && !idex_flush;
                mem_v <= ex_v;
                wb_v  <= mem_v;
            end
        end
    end

    assign mem_timeout = timeout_q || (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev == EV_BRANCH),
        .clr   (1'b0),
        .count (flush_cnt)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (freeze),
        .clr   (!freeze),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle decode table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int MEM_TO = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             id_valid, id_uses_rs1, id_uses_rs2, id_serialize;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_flush, memwb_bubble, pc_sel_target, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_serialize(id_serialize),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .pc_sel_target(pc_sel_target),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble, pc_sel_target}
    wire [7:0] ctl = {pc_write, ifid_write, idex_write, exmem_write,
                      ifid_flush, idex_flush, memwb_bubble, pc_sel_target};

    localparam logic [7:0] C_RUN   = 8'hF0;
    localparam logic [7:0] C_STALL = 8'h34;
    localparam logic [7:0] C_BR    = 8'hFD;
    localparam logic [7:0] C_FRZ   = 8'h02;
    localparam logic [7:0] C_RST   = 8'h0E;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2, ser;
        logic [4:0] rd;
        logic       ld, br, req, rdy;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic ser,
                          input logic [4:0] rd, input logic ld, input logic br,
                          input logic req, input logic rdy);
        id_valid = v;  id_rs1 = r1;  id_rs2 = r2;
        id_uses_rs1 = u1;  id_uses_rs2 = u2;  id_serialize = ser;
        ex_rd = rd;  ex_mem_read = ld;  ex_branch_taken = br;
        mem_req = req;  mem_ready = rdy;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check combinational controls mid-cycle, then commit the cycle.
    task automatic cyc_chk(input string name, input logic [7:0] exp);
        #2;
        chk(name, {24'd0, ctl}, {24'd0, exp});
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic fill_pipe();
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{"idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN};
        tbl[1]  = '{"lu_rs2",         1, 1, 5, 1, 1, 0, 5, 1, 0, 0, 0, C_STALL};
        tbl[2]  = '{"lu_rs1",         1, 7, 3, 1, 1, 0, 7, 1, 0, 0, 0, C_STALL};
        tbl[3]  = '{"lu_rs1_unused",  1, 7, 3, 0, 1, 0, 7, 1, 0, 0, 0, C_RUN};
        tbl[4]  = '{"lu_rd_zero",     1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, C_RUN};
        tbl[5]  = '{"match_no_load",  1, 5, 5, 1, 1, 0, 5, 0, 0, 0, 0, C_RUN};
        tbl[6]  = '{"lu_no_match",    1, 4, 6, 1, 1, 0, 5, 1, 0, 0, 0, C_RUN};
        tbl[7]  = '{"branch",         1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR};
        tbl[8]  = '{"branch_over_lu", 1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, C_BR};
        tbl[9]  = '{"freeze",         1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ};
        tbl[10] = '{"freeze_over_br", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ};
        tbl[11] = '{"freeze_over_lu", 1, 5, 0, 1, 0, 0, 5, 1, 0, 1, 0, C_FRZ};
        tbl[12] = '{"mem_done",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN};
        tbl[13] = '{"ready_no_req",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN};
        tbl[14] = '{"ser_empty_pipe", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_RUN};

        // Reset forces bubbles regardless of the inputs.
        set_in(1, 5, 5, 1, 1, 1, 5, 1, 1, 1, 0);
        rst_n = 1'b0;
        #3;
        chk("rst_ctl", {24'd0, ctl}, {24'd0, C_RST});
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_reset();
            set_in(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].ser,
                   tbl[i].rd, tbl[i].ld, tbl[i].br, tbl[i].req, tbl[i].rdy);
            cyc_chk(tbl[i].name, tbl[i].exp);
        end

        // Load-use: one bubble, then the load has moved on.
        do_reset();
        set_in(1, 1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        cyc_chk("lu_seq_stall", C_STALL);
        chk("lu_seq_stall_cnt", 32'(stall_cnt), 1);
        chk("lu_seq_state", 32'(dut.state), 32'(RUN));
        set_in(1, 1, 5, 0, 1, 0, 9, 0, 0, 0, 0);
        cyc_chk("lu_seq_resume", C_RUN);
        chk("lu_seq_stall_cnt2", 32'(stall_cnt), 1);

        // Branch: one redirect cycle.
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc_chk("br_seq_redirect", C_BR);
        chk("br_seq_flush_cnt", 32'(flush_cnt), 1);
        idle();
        cyc_chk("br_seq_after", C_RUN);
        chk("br_seq_flush_cnt2", 32'(flush_cnt), 1);

        // Memory wait: 4 frozen cycles with ex_v held; timeout at 3.
        do_reset();
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            cyc_chk($sformatf("mw_freeze%0d", c), C_FRZ);
            chk($sformatf("mw_ex_v%0d", c), 32'(dut.ex_v), 1);
            chk($sformatf("mw_state%0d", c), 32'(dut.state), 32'(MEM_WAIT));
            chk($sformatf("mw_timeout%0d", c), 32'(mem_timeout), (c >= MEM_TO) ? 1 : 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc_chk("mw_resume", C_RUN);
        chk("mw_stall_cnt", 32'(stall_cnt), 4);
        chk("mw_state_back", 32'(dut.state), 32'(RUN));
        idle();
        tick();
        chk("mw_timeout_sticky", 32'(mem_timeout), 1);

        // Serialise into a full pipe: three drain cycles, release in the fourth.
        do_reset();
        fill_pipe();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            cyc_chk($sformatf("ser_drain%0d", c), C_STALL);
            chk($sformatf("ser_state%0d", c), 32'(dut.state), 32'(DRAIN));
        end
        cyc_chk("ser_release", C_RUN);
        chk("ser_state_run", 32'(dut.state), 32'(RUN));
        chk("ser_stall_cnt", 32'(stall_cnt), 3);

        // Branch on the serialise cycle wins and stays in RUN.
        do_reset();
        fill_pipe();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc_chk("ser_br_cycle1", C_BR);
        chk("ser_br1_state", 32'(dut.state), 32'(RUN));
        chk("ser_br1_flush_cnt", 32'(flush_cnt), 1);

        // Branch while already draining returns to RUN.
        do_reset();
        fill_pipe();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc_chk("ser_br2_drain", C_STALL);
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc_chk("ser_br2_branch", C_BR);
        chk("ser_br2_state", 32'(dut.state), 32'(RUN));

        // Timeout, then async reset in the middle of a drain.
        do_reset();
        fill_pipe();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) tick();
        chk("rd_timeout_set", 32'(mem_timeout), 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        chk("rd_state_drain", 32'(dut.state), 32'(DRAIN));
        #3;
        rst_n = 1'b0;
        #1;
        chk("rd_state_run", 32'(dut.state), 32'(RUN));
        chk("rd_stall_cnt", 32'(stall_cnt), 0);
        chk("rd_timeout_clr", 32'(mem_timeout), 0);
        chk("rd_ex_v", 32'(dut.ex_v), 0);
        chk("rd_ctl", {24'd0, ctl}, {24'd0, C_RST});
        tick();
        rst_n = 1'b1;
        idle();

        // Counter saturation at all-ones.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) tick();
        chk("sat_stall_cnt", 32'(stall_cnt), (1 << CNT_W) - 1);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
